// File: rtl/game_flow_controller.sv
// game_flow_controller
//
// Game-flow sequencer and screen mux for the pinball top level. Owns the
// lives and score counters, provides a pause mode with a dimmed playfield,
// frame-timed holds after a lost ball and at game over, and selects the RGB
// stream sent to the VGA controller.
//
// Optional feature: define HIGH_SCORE_EN to keep a high score across games.
// Without it high_score is tied to zero and no comparator/register is built.
//
// Ports:
//   clk                 pixel clock
//   resetN              asynchronous active-low reset
//   startOfFrame        one-cycle pulse per VGA frame
//   keyStartIsPressed   start/restart key level
//   keyPauseIsPressed   pause key level
//   ballLost            one-cycle pulse, ball left the playfield
//   scoreInc            one-cycle pulse, award one point
//   RGB_screen_welcome  welcome screen pixel (RRRGGGBB)
//   RGB_screen_main     playfield pixel (RRRGGGBB)
//   RGB_screen_end      end screen pixel (RRRGGGBB)
//   RGB                 registered selected pixel
//   start               high in PLAY, PAUSE, LOST
//   paused              high in PAUSE
//   game_end            high in END
//   life                remaining lives
//   score               current score (saturating)
//   high_score          best completed score
//
// state   | meaning
// --------+------------------------------------------------------------
// WELCOME | welcome screen, waiting for a start key press
// PLAY    | game running, scoring and ball loss active
// PAUSE   | game frozen, playfield shown dimmed
// LOST    | frozen for LOST_HOLD_FRAMES frames after a lost ball
// END     | game over screen, start accepted after END_HOLD_FRAMES frames

module game_flow_controller #(
    parameter int LIFE_W           = 4,
    parameter int INIT_LIVES       = 3,
    parameter int SCORE_W          = 8,
    parameter int LOST_HOLD_FRAMES = 60,
    parameter int END_HOLD_FRAMES  = 120
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               keyStartIsPressed,
    input  logic               keyPauseIsPressed,
    input  logic               ballLost,
    input  logic               scoreInc,
    input  logic [7:0]         RGB_screen_welcome,
    input  logic [7:0]         RGB_screen_main,
    input  logic [7:0]         RGB_screen_end,
    output logic [7:0]         RGB,
    output logic               start,
    output logic               paused,
    output logic               game_end,
    output logic [LIFE_W-1:0]  life,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int MAX_HOLD = (LOST_HOLD_FRAMES > END_HOLD_FRAMES) ?
                              LOST_HOLD_FRAMES : END_HOLD_FRAMES;
    localparam int CNT_W    = $clog2(MAX_HOLD + 1);

    localparam logic [CNT_W-1:0]   LOST_LAST = CNT_W'(LOST_HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0]   END_SAT   = CNT_W'(END_HOLD_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        S_WELCOME,
        S_PLAY,
        S_PAUSE,
        S_LOST,
        S_END
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_start_prev;
    logic               r_pause_prev;
    logic [LIFE_W-1:0]  r_life;
    logic [LIFE_W-1:0]  w_life_nxt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   w_frame_cnt_nxt;
    logic [7:0]         r_rgb;
    logic [7:0]         w_rgb_sel;
    logic               r_start;
    logic               r_paused;
    logic               r_game_end;
    logic               w_start_rise;
    logic               w_pause_rise;

    // prev registers reset to 1 so a key held through reset must be
    // released before it can trigger anything
    assign w_start_rise = keyStartIsPressed & ~r_start_prev;
    assign w_pause_rise = keyPauseIsPressed & ~r_pause_prev;

    always_comb begin
        w_state_nxt     = r_state;
        w_life_nxt      = r_life;
        w_score_nxt     = r_score;
        w_frame_cnt_nxt = r_frame_cnt;
        unique case (r_state)
            S_WELCOME: begin
                if (w_start_rise) begin
                    w_state_nxt = S_PLAY;
                    w_life_nxt  = LIFE_W'(INIT_LIVES);
                    w_score_nxt = '0;
                end
            end
            S_PLAY: begin
                // a point scored in the same cycle as a lost ball still counts
                if (scoreInc && (r_score != SCORE_MAX))
                    w_score_nxt = r_score + SCORE_W'(1);
                if (ballLost) begin
                    w_life_nxt      = r_life - LIFE_W'(1);
                    w_frame_cnt_nxt = '0;
                    w_state_nxt     = (r_life == LIFE_W'(1)) ? S_END : S_LOST;
                end else if (w_pause_rise) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_pause_rise)
                    w_state_nxt = S_PLAY;
            end
            S_LOST: begin
                if (startOfFrame) begin
                    if (r_frame_cnt == LOST_LAST) begin
                        w_state_nxt     = S_PLAY;
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                    end
                end
            end
            S_END: begin
                if (startOfFrame && (r_frame_cnt != END_SAT))
                    w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                if (w_start_rise && (r_frame_cnt == END_SAT)) begin
                    w_state_nxt     = S_WELCOME;
                    w_frame_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_WELCOME;
            end
        endcase
    end

    // Pixel select uses the current state; the register adds one cycle latency
    always_comb begin
        w_rgb_sel = RGB_screen_welcome;
        unique case (r_state)
            S_WELCOME: w_rgb_sel = RGB_screen_welcome;
            S_PLAY,
            S_LOST:    w_rgb_sel = RGB_screen_main;
            S_PAUSE:   w_rgb_sel = {1'b0, RGB_screen_main[7:6],
                                    1'b0, RGB_screen_main[4:3],
                                    1'b0, RGB_screen_main[1]};
            S_END:     w_rgb_sel = RGB_screen_end;
            default:   w_rgb_sel = RGB_screen_welcome;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_WELCOME;
            r_start_prev <= 1'b1;
            r_pause_prev <= 1'b1;
            r_life       <= '0;
            r_score      <= '0;
            r_frame_cnt  <= '0;
            r_rgb        <= '0;
            r_start      <= 1'b0;
            r_paused     <= 1'b0;
            r_game_end   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_prev <= keyStartIsPressed;
            r_pause_prev <= keyPauseIsPressed;
            r_life       <= w_life_nxt;
            r_score      <= w_score_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_rgb        <= w_rgb_sel;
            // flags track the state being entered so they change with it
            r_start      <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_PAUSE) ||
                            (w_state_nxt == S_LOST);
            r_paused     <= (w_state_nxt == S_PAUSE);
            r_game_end   <= (w_state_nxt == S_END);
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] r_high_score;
    logic               w_game_over;

    assign w_game_over = (r_state == S_PLAY) && (w_state_nxt == S_END);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_high_score <= '0;
        end else if (w_game_over && (r_score > r_high_score)) begin
            r_high_score <= r_score;
        end
    end

    assign high_score = r_high_score;
`else
    assign high_score = '0;
`endif

    assign RGB      = r_rgb;
    assign start    = r_start;
    assign paused   = r_paused;
    assign game_end = r_game_end;
    assign life     = r_life;
    assign score    = r_score;

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;

    localparam logic [7:0] C_WEL  = 8'h11;
    localparam logic [7:0] C_MAIN = 8'hFF;
    localparam logic [7:0] C_DIM  = 8'h6D;
    localparam logic [7:0] C_END  = 8'h33;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       keyStartIsPressed;
    logic       keyPauseIsPressed;
    logic       ballLost;
    logic       scoreInc;
    logic [7:0] RGB_screen_welcome;
    logic [7:0] RGB_screen_main;
    logic [7:0] RGB_screen_end;
    logic [7:0] RGB;
    logic       start;
    logic       paused;
    logic       game_end;
    logic [3:0] life;
    logic [7:0] score;
    logic [7:0] high_score;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef HIGH_SCORE_EN
    localparam bit HS_ON = 1'b1;
`else
    localparam bit HS_ON = 1'b0;
`endif

    game_flow_controller dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .keyStartIsPressed (keyStartIsPressed),
        .keyPauseIsPressed (keyPauseIsPressed),
        .ballLost          (ballLost),
        .scoreInc          (scoreInc),
        .RGB_screen_welcome(RGB_screen_welcome),
        .RGB_screen_main   (RGB_screen_main),
        .RGB_screen_end    (RGB_screen_end),
        .RGB               (RGB),
        .start             (start),
        .paused            (paused),
        .game_end          (game_end),
        .life              (life),
        .score             (score),
        .high_score        (high_score)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic press_start();
        keyStartIsPressed = 1'b1;
        tick();
        keyStartIsPressed = 1'b0;
        tick();
    endtask

    task automatic press_pause();
        keyPauseIsPressed = 1'b1;
        tick();
        keyPauseIsPressed = 1'b0;
        tick();
    endtask

    task automatic pulse_lost();
        ballLost = 1'b1;
        tick();
        ballLost = 1'b0;
        tick();
    endtask

    task automatic add_points(input int n);
        for (int i = 0; i < n; i++) begin
            scoreInc = 1'b1;
            tick();
        end
        scoreInc = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        keyStartIsPressed = 1'b1;   // held through reset
        tick();
        tick();
        n_checks++;
        if (RGB !== 8'h00 || start !== 1'b0 || paused !== 1'b0 || game_end !== 1'b0)
            $display("FAIL reset_flags: RGB=%h start=%b paused=%b end=%b, want 00/0/0/0",
                     RGB, start, paused, game_end);
        else n_pass++;
        n_checks++;
        if (life !== 4'd0 || score !== 8'd0 || high_score !== 8'd0)
            $display("FAIL reset_counts: life=%0d score=%0d hs=%0d, want 0/0/0",
                     life, score, high_score);
        else n_pass++;
        resetN = 1'b1;
        tick();
        tick();
        n_checks++;
        if (start !== 1'b0 || RGB !== C_WEL)
            $display("FAIL held_key_ignored: start=%b RGB=%h, want 0/%h", start, RGB, C_WEL);
        else n_pass++;
        keyStartIsPressed = 1'b0;
        tick();
    endtask

    task automatic test_start();
        keyStartIsPressed = 1'b1;
        tick();
        n_checks++;
        if (start !== 1'b1 || life !== 4'd3 || score !== 8'd0)
            $display("FAIL start_game: start=%b life=%0d score=%0d, want 1/3/0",
                     start, life, score);
        else n_pass++;
        tick();
        n_checks++;
        if (RGB !== C_MAIN)
            $display("FAIL rgb_main: RGB=%h, want %h", RGB, C_MAIN);
        else n_pass++;
        keyStartIsPressed = 1'b0;
        tick();
    endtask

    task automatic test_pause();
        keyPauseIsPressed = 1'b1;
        tick();
        n_checks++;
        if (paused !== 1'b1 || start !== 1'b1)
            $display("FAIL pause_enter: paused=%b start=%b, want 1/1", paused, start);
        else n_pass++;
        tick();
        n_checks++;
        if (RGB !== C_DIM)
            $display("FAIL rgb_dim: RGB=%h, want %h", RGB, C_DIM);
        else n_pass++;
        keyPauseIsPressed = 1'b0;
        tick();
        pulse_lost();
        add_points(1);
        n_checks++;
        if (life !== 4'd3 || score !== 8'd0 || paused !== 1'b1)
            $display("FAIL pause_ignore: life=%0d score=%0d paused=%b, want 3/0/1",
                     life, score, paused);
        else n_pass++;
        keyPauseIsPressed = 1'b1;
        tick();
        n_checks++;
        if (paused !== 1'b0 || start !== 1'b1)
            $display("FAIL pause_exit: paused=%b start=%b, want 0/1", paused, start);
        else n_pass++;
        tick();
        n_checks++;
        if (RGB !== C_MAIN)
            $display("FAIL rgb_unpaused: RGB=%h, want %h", RGB, C_MAIN);
        else n_pass++;
        keyPauseIsPressed = 1'b0;
        tick();
    endtask

    task automatic test_lost();
        // frame pulse on the loss cycle must not count toward the hold
        ballLost = 1'b1;
        startOfFrame = 1'b1;
        tick();
        ballLost = 1'b0;
        startOfFrame = 1'b0;
        n_checks++;
        if (life !== 4'd2 || start !== 1'b1 || game_end !== 1'b0 || paused !== 1'b0)
            $display("FAIL lost_enter: life=%0d start=%b end=%b paused=%b, want 2/1/0/0",
                     life, start, game_end, paused);
        else n_pass++;
        tick();
        press_pause();
        n_checks++;
        if (paused !== 1'b0)
            $display("FAIL lost_pause_ignored: paused=%b, want 0", paused);
        else n_pass++;
        frames(59);
        add_points(1);
        n_checks++;
        if (score !== 8'd0)
            $display("FAIL lost_hold_59: score=%0d, want 0", score);
        else n_pass++;
        frames(1);
        add_points(1);
        n_checks++;
        if (score !== 8'd1 || life !== 4'd2)
            $display("FAIL lost_release_60: score=%0d life=%0d, want 1/2", score, life);
        else n_pass++;
    endtask

    task automatic test_saturate();
        add_points(253);
        n_checks++;
        if (score !== 8'd254)
            $display("FAIL score_254: score=%0d, want 254", score);
        else n_pass++;
        add_points(46);
        n_checks++;
        if (score !== 8'd255)
            $display("FAIL score_sat: score=%0d, want 255", score);
        else n_pass++;
    endtask

    task automatic test_game_over();
        pulse_lost();
        n_checks++;
        if (life !== 4'd1 || game_end !== 1'b0)
            $display("FAIL second_loss: life=%0d end=%b, want 1/0", life, game_end);
        else n_pass++;
        frames(60);
        ballLost = 1'b1;
        tick();
        ballLost = 1'b0;
        n_checks++;
        if (game_end !== 1'b1 || life !== 4'd0 || start !== 1'b0 || score !== 8'd255)
            $display("FAIL game_over: end=%b life=%0d start=%b score=%0d, want 1/0/0/255",
                     game_end, life, start, score);
        else n_pass++;
        tick();
        n_checks++;
        if (RGB !== C_END || high_score !== (HS_ON ? 8'd255 : 8'd0))
            $display("FAIL end_screen: RGB=%h hs=%0d, want %h/%0d",
                     RGB, high_score, C_END, HS_ON ? 255 : 0);
        else n_pass++;
    endtask

    task automatic test_end_hold();
        frames(119);
        press_start();
        n_checks++;
        if (game_end !== 1'b1 || score !== 8'd255)
            $display("FAIL end_early_start: end=%b score=%0d, want 1/255", game_end, score);
        else n_pass++;
        frames(1);
        keyStartIsPressed = 1'b1;
        tick();
        n_checks++;
        if (game_end !== 1'b0 || start !== 1'b0)
            $display("FAIL end_exit: end=%b start=%b, want 0/0", game_end, start);
        else n_pass++;
        tick();
        n_checks++;
        if (RGB !== C_WEL)
            $display("FAIL rgb_welcome: RGB=%h, want %h", RGB, C_WEL);
        else n_pass++;
        keyStartIsPressed = 1'b0;
        tick();
    endtask

    task automatic play_game(input int pts);
        press_start();
        add_points(pts);
        pulse_lost();
        frames(60);
        pulse_lost();
        frames(60);
        pulse_lost();
    endtask

    task automatic test_high_score();
        // reset in the middle of a lost-ball hold
        press_start();
        add_points(3);
        pulse_lost();
        frames(5);
        resetN = 1'b0;
        #1;
        n_checks++;
        if (start !== 1'b0 || life !== 4'd0 || score !== 8'd0 || RGB !== 8'h00)
            $display("FAIL midgame_reset: start=%b life=%0d score=%0d RGB=%h, want 0/0/0/00",
                     start, life, score, RGB);
        else n_pass++;
        tick();
        resetN = 1'b1;
        tick();
        play_game(7);
        n_checks++;
        if (game_end !== 1'b1 || score !== 8'd7 || high_score !== (HS_ON ? 8'd7 : 8'd0))
            $display("FAIL hs_game1: end=%b score=%0d hs=%0d, want 1/7/%0d",
                     game_end, score, high_score, HS_ON ? 7 : 0);
        else n_pass++;
        frames(120);
        press_start();
        play_game(4);
        n_checks++;
        if (game_end !== 1'b1 || score !== 8'd4 || high_score !== (HS_ON ? 8'd7 : 8'd0))
            $display("FAIL hs_game2: end=%b score=%0d hs=%0d, want 1/4/%0d",
                     game_end, score, high_score, HS_ON ? 7 : 0);
        else n_pass++;
    endtask

    initial begin
        resetN             = 1'b0;
        startOfFrame       = 1'b0;
        keyStartIsPressed  = 1'b0;
        keyPauseIsPressed  = 1'b0;
        ballLost           = 1'b0;
        scoreInc           = 1'b0;
        RGB_screen_welcome = C_WEL;
        RGB_screen_main    = C_MAIN;
        RGB_screen_end     = C_END;
        test_reset();
        test_start();
        test_pause();
        test_lost();
        test_saturate();
        test_game_over();
        test_end_hold();
        test_high_score();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
